// File: rtl/e203_rst_seq_if.sv
// Handshake bundle for the reset sequencer: lock/pad/request inputs and the
// registered per-domain reset outputs with status.
interface e203_rst_seq_if #(
  parameter int N_CH = 4
);
  logic            pll_lock;
  logic            erst_n;
  logic            sw_rst_req;
  logic [N_CH-1:0] rst_n_out;
  logic            rst_done;
  logic [1:0]      rst_cause;

  modport master (
    output pll_lock, erst_n, sw_rst_req,
    input  rst_n_out, rst_done, rst_cause
  );

  modport slave (
    input  pll_lock, erst_n, sw_rst_req,
    output rst_n_out, rst_done, rst_cause
  );
endinterface

// File: rtl/e203_rst_seq.sv
// Lock-qualified, debounced, multi-channel reset sequencer. Domains are
// released in ascending order after DLY cycles of qualified-good, spaced GAP
// cycles apart; any lock loss, external reset or software request drops all
// domains at once and restarts the sequence.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_HOLD  | all domains in reset, waiting for lock & filtered pad high
// S_WAIT  | initial delay running before channel 0 is released
// S_REL   | releasing channels 1..N_CH-1, one every GAP cycles
// S_RUN   | all domains released, rst_done high
module e203_rst_seq #(
  parameter int N_CH = 4,
  parameter int DLY  = 16,
  parameter int GAP  = 8,
  parameter int DBNC = 4
) (
  input  logic          clk,
  input  logic          rst,
  e203_rst_seq_if.slave bus
);

  localparam int MX01 = (DLY > GAP) ? DLY : GAP;
  localparam int MAXC = (MX01 > DBNC) ? MX01 : DBNC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int KW   = $clog2(N_CH + 1);

  typedef enum logic [1:0] {S_HOLD, S_WAIT, S_REL, S_RUN} state_t;

  state_t          state;
  logic            lock_m, lock_s;
  logic            erst_m, erst_s, erst_f;
  logic [CW-1:0]   db_cnt;
  logic [CW-1:0]   cnt;
  logic [KW-1:0]   ch;
  logic [N_CH-1:0] rst_n_q;
  logic            done_q;
  logic [1:0]      cause_q;
  logic            good;
  logic [1:0]      cause_code;
  logic            cause_any;

  // Two-flop synchronisers for the asynchronous lock and pad inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
      erst_m <= 1'b0;
      erst_s <= 1'b0;
    end else begin
      lock_m <= bus.pll_lock;
      lock_s <= lock_m;
      erst_m <= bus.erst_n;
      erst_s <= erst_m;
    end
  end

  // Pad debounce: flip erst_f only after DBNC consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt <= '0;
      erst_f <= 1'b0;
    end else if (erst_s == erst_f) begin
      db_cnt <= '0;
    end else if (db_cnt == CW'(DBNC - 1)) begin
      db_cnt <= '0;
      erst_f <= erst_s;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Qualification and priority-encoded reset cause (0 means none active).
  always_comb begin
    good       = lock_s & erst_f;
    cause_code = 2'd0;
    if (!lock_s)             cause_code = 2'd1;
    else if (!erst_f)        cause_code = 2'd2;
    else if (bus.sw_rst_req) cause_code = 2'd3;
  end

  assign cause_any = (cause_code != 2'd0);

  // Sequencing FSM; outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_HOLD;
      cnt     <= '0;
      ch      <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
      cause_q <= 2'd0;
    end else begin
      if (state != S_HOLD && cause_any) begin
        state   <= S_HOLD;
        cnt     <= '0;
        ch      <= '0;
        rst_n_q <= '0;
        done_q  <= 1'b0;
        cause_q <= cause_code;
      end else begin
        case (state)
          S_HOLD: begin
            if (good) begin
              state <= S_WAIT;
              cnt   <= '0;
            end
          end
          S_WAIT: begin
            if (cnt == CW'(DLY - 1)) begin
              cnt     <= '0;
              ch      <= KW'(1);
              rst_n_q <= N_CH'(1);
              if (N_CH == 1) begin
                state  <= S_RUN;
                done_q <= 1'b1;
              end else begin
                state <= S_REL;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_REL: begin
            if (cnt == CW'(GAP - 1)) begin
              cnt     <= '0;
              ch      <= ch + 1'b1;
              rst_n_q <= (rst_n_q << 1) | N_CH'(1);
              if (ch == KW'(N_CH - 1)) begin
                state  <= S_RUN;
                done_q <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_RUN:   state <= S_RUN;
          default: state <= S_HOLD;
        endcase
      end
    end
  end

  assign bus.rst_n_out = rst_n_q;
  assign bus.rst_done  = done_q;
  assign bus.rst_cause = cause_q;

endmodule

// File: tb/tb_e203_rst_seq.sv
// Bench for e203_rst_seq: two instances (4-channel default and 1-channel
// DLY=GAP=1) share stimulus and are checked each cycle against an
// elapsed-time model, plus fixed edge-numbered expectations.
module tb_e203_rst_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pll_lock = 1'b0;
  logic erst_n = 1'b1;
  logic sw_rst_req = 1'b0;

  always #5 clk = ~clk;

  e203_rst_seq_if #(.N_CH(4)) if_a ();
  e203_rst_seq_if #(.N_CH(1)) if_b ();

  assign if_a.pll_lock   = pll_lock;
  assign if_a.erst_n     = erst_n;
  assign if_a.sw_rst_req = sw_rst_req;
  assign if_b.pll_lock   = pll_lock;
  assign if_b.erst_n     = erst_n;
  assign if_b.sw_rst_req = sw_rst_req;

  e203_rst_seq #(.N_CH(4), .DLY(16), .GAP(8), .DBNC(4)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a.slave));
  e203_rst_seq #(.N_CH(1), .DLY(1), .GAP(1), .DBNC(4)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b.slave));

  function automatic int p_n(int i);   return (i == 0) ? 4  : 1; endfunction
  function automatic int p_dly(int i); return (i == 0) ? 16 : 1; endfunction
  function automatic int p_gap(int i); return (i == 0) ? 8  : 1; endfunction

  localparam int M_DBNC = 4;

  // Model: delay lines for the synchronisers, a window of the last DBNC
  // synchronised pad samples, and per instance the time since the sequence
  // started; released-channel count follows directly from that time.
  int       edge_n = 0;
  bit [1:0] m_lk = '0;
  bit [1:0] m_er = '0;
  bit       m_win [M_DBNC];
  bit       m_ef = 1'b0;
  bit       m_act [2];
  int       m_t [2];
  int       m_rel [2];
  int       m_cause [2];

  int n_cmp = 0;
  int n_bad = 0;

  initial begin
    for (int j = 0; j < M_DBNC; j++) m_win[j] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 1'b0; m_t[i] = 0; m_rel[i] = 0; m_cause[i] = 0;
    end
    forever begin
      bit ls, ef, good, same;
      int c, r;
      @(posedge clk);
      edge_n++;
      ls = m_lk[1];
      ef = m_ef;
      if (rst) begin
        m_lk = '0; m_er = '0; m_ef = 1'b0;
        for (int j = 0; j < M_DBNC; j++) m_win[j] = 1'b0;
        for (int i = 0; i < 2; i++) begin
          m_act[i] = 1'b0; m_t[i] = 0; m_rel[i] = 0; m_cause[i] = 0;
        end
      end else begin
        good = ls && ef;
        c = !ls ? 1 : (!ef ? 2 : (sw_rst_req ? 3 : 0));
        for (int i = 0; i < 2; i++) begin
          if (!m_act[i]) begin
            if (good) begin m_act[i] = 1'b1; m_t[i] = 0; end
          end else if (c != 0) begin
            m_act[i] = 1'b0; m_rel[i] = 0; m_cause[i] = c;
          end else begin
            m_t[i]++;
            if (m_t[i] >= p_dly(i)) begin
              r = 1 + (m_t[i] - p_dly(i)) / p_gap(i);
              m_rel[i] = (r > p_n(i)) ? p_n(i) : r;
            end
          end
        end
        for (int j = M_DBNC - 1; j > 0; j--) m_win[j] = m_win[j-1];
        m_win[0] = m_er[1];
        same = 1'b1;
        for (int j = 1; j < M_DBNC; j++) if (m_win[j] != m_win[0]) same = 1'b0;
        if (same) m_ef = m_win[0];
        m_lk = {m_lk[0], pll_lock};
        m_er = {m_er[0], erst_n};
      end
    end
  end

  // Advance one edge and compare both instances against the model.
  task automatic tick();
    logic [3:0] got_o, exp_o;
    logic       got_d, exp_d;
    logic [1:0] got_c, exp_c;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        got_o = if_a.rst_n_out; got_d = if_a.rst_done; got_c = if_a.rst_cause;
      end else begin
        got_o = {3'b000, if_b.rst_n_out}; got_d = if_b.rst_done; got_c = if_b.rst_cause;
      end
      exp_o = 4'((1 << m_rel[i]) - 1);
      exp_d = (m_rel[i] == p_n(i));
      exp_c = 2'(m_cause[i]);
      n_cmp++;
      if (got_o !== exp_o || got_d !== exp_d || got_c !== exp_c) begin
        n_bad++;
        $display("FAIL model inst%0d edge %0d: got out=%h done=%b cause=%0d, want out=%h done=%b cause=%0d",
                 i, edge_n, got_o, got_d, got_c, exp_o, exp_d, exp_c);
      end
    end
  endtask

  task automatic go_to(int n);
    while (edge_n < n) tick();
  endtask

  task automatic chk(string nm, int got, int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s edge %0d: got %0d, want %0d", nm, edge_n, got, want);
    end
  endtask

  initial begin
    int lk_hold, er_hold;
    go_to(2);
    rst = 1'b0;
    chk("a_out_reset", int'(if_a.rst_n_out), 0);
    chk("a_cause_reset", int'(if_a.rst_cause), 0);
    go_to(9);   pll_lock = 1'b1;
    go_to(12);  chk("b_out_wait", int'(if_b.rst_n_out), 0);
    go_to(13);  chk("b_out_rel", int'(if_b.rst_n_out), 1);
                chk("b_done_rel", int'(if_b.rst_done), 1);
    go_to(27);  chk("a_out_27", int'(if_a.rst_n_out), 0);
    go_to(28);  chk("a_out_28", int'(if_a.rst_n_out), 1);
    go_to(36);  chk("a_out_36", int'(if_a.rst_n_out), 3);
    go_to(44);  chk("a_out_44", int'(if_a.rst_n_out), 7);
    go_to(51);  chk("a_done_51", int'(if_a.rst_done), 0);
    go_to(52);  chk("a_out_52", int'(if_a.rst_n_out), 15);
                chk("a_done_52", int'(if_a.rst_done), 1);
                chk("a_cause_52", int'(if_a.rst_cause), 0);
    // one-cycle lock loss
    go_to(99);  pll_lock = 1'b0;
    go_to(100); pll_lock = 1'b1;
    go_to(101); chk("a_out_101", int'(if_a.rst_n_out), 15);
    go_to(102); chk("a_out_lockloss", int'(if_a.rst_n_out), 0);
                chk("a_done_lockloss", int'(if_a.rst_done), 0);
                chk("a_cause_lockloss", int'(if_a.rst_cause), 1);
    go_to(118); chk("a_out_118", int'(if_a.rst_n_out), 0);
    go_to(119); chk("a_out_119", int'(if_a.rst_n_out), 1);
    // 3-cycle pad glitch is filtered
    go_to(150); erst_n = 1'b0;
    go_to(153); erst_n = 1'b1;
    go_to(165); chk("a_out_glitch", int'(if_a.rst_n_out), 15);
                chk("a_cause_glitch", int'(if_a.rst_cause), 1);
    // 6-cycle pad low resets everything
    go_to(170); erst_n = 1'b0;
    go_to(176); erst_n = 1'b1;
                chk("a_out_176", int'(if_a.rst_n_out), 15);
    go_to(177); chk("a_out_ext", int'(if_a.rst_n_out), 0);
                chk("a_cause_ext", int'(if_a.rst_cause), 2);
    go_to(198); chk("a_out_198", int'(if_a.rst_n_out), 0);
    go_to(199); chk("a_out_199", int'(if_a.rst_n_out), 1);
    go_to(207); chk("a_out_207", int'(if_a.rst_n_out), 3);
    // software request mid-release
    go_to(208); sw_rst_req = 1'b1;
                chk("a_out_208", int'(if_a.rst_n_out), 3);
    go_to(209); sw_rst_req = 1'b0;
                chk("a_out_sw", int'(if_a.rst_n_out), 0);
                chk("a_cause_sw", int'(if_a.rst_cause), 3);
    go_to(225); chk("a_out_225", int'(if_a.rst_n_out), 0);
    go_to(226); chk("a_out_226", int'(if_a.rst_n_out), 1);
    go_to(234); chk("a_out_234", int'(if_a.rst_n_out), 3);
    go_to(242); chk("a_out_242", int'(if_a.rst_n_out), 7);
    go_to(250); chk("a_out_250", int'(if_a.rst_n_out), 15);
                chk("a_done_250", int'(if_a.rst_done), 1);
    // all three causes reach the FSM on edge 263
    go_to(256); erst_n = 1'b0;
    go_to(260); pll_lock = 1'b0;
    go_to(262); sw_rst_req = 1'b1;
                chk("a_out_262", int'(if_a.rst_n_out), 15);
    go_to(263); sw_rst_req = 1'b0;
                chk("a_out_multi", int'(if_a.rst_n_out), 0);
                chk("a_cause_multi", int'(if_a.rst_cause), 1);
                chk("b_cause_multi", int'(if_b.rst_cause), 1);
    go_to(270); sw_rst_req = 1'b1;
    go_to(271); sw_rst_req = 1'b0;
    go_to(272); chk("a_cause_hold_sw", int'(if_a.rst_cause), 1);
                chk("a_out_hold_sw", int'(if_a.rst_n_out), 0);
    go_to(280); pll_lock = 1'b1; erst_n = 1'b1;
    go_to(287); chk("b_out_287", int'(if_b.rst_n_out), 0);
    go_to(288); chk("b_out_288", int'(if_b.rst_n_out), 1);
    go_to(302); chk("a_out_302", int'(if_a.rst_n_out), 0);
    go_to(303); chk("a_out_303", int'(if_a.rst_n_out), 1);
    // rst while the 1-channel instance sits in WAIT
    go_to(320); sw_rst_req = 1'b1;
    go_to(321); sw_rst_req = 1'b0;
                chk("b_cause_sw", int'(if_b.rst_cause), 3);
    go_to(322); rst = 1'b1;
                chk("b_out_wait2", int'(if_b.rst_n_out), 0);
    go_to(323); rst = 1'b0;
                chk("b_out_rst", int'(if_b.rst_n_out), 0);
                chk("b_cause_rst", int'(if_b.rst_cause), 0);
                chk("a_cause_rst", int'(if_a.rst_cause), 0);
                chk("a_out_rst", int'(if_a.rst_n_out), 0);
    go_to(330); chk("b_out_330", int'(if_b.rst_n_out), 0);
    go_to(331); chk("b_out_331", int'(if_b.rst_n_out), 1);
                chk("b_done_331", int'(if_b.rst_done), 1);
    // randomized phase
    lk_hold = 0;
    er_hold = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick();
      rst = ($urandom_range(0, 599) == 0);
      if (lk_hold > 0) begin
        lk_hold--;
        if (lk_hold == 0) pll_lock = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        pll_lock = 1'b0;
        lk_hold = $urandom_range(1, 10);
      end
      if (er_hold > 0) begin
        er_hold--;
        if (er_hold == 0) erst_n = 1'b1;
      end else if ($urandom_range(0, 199) == 0) begin
        erst_n = 1'b0;
        er_hold = $urandom_range(1, 8);
      end
      sw_rst_req = ($urandom_range(0, 149) == 0);
    end
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
